// File: rtl/led_pkg.sv
// Shared definitions for the LED pulse stretcher: channel state encoding,
// board-level default timing and a parameter range helper.
package led_pkg;

  // Per-channel phase. The unused code 2'd3 is treated as corrupt and sends
  // the channel back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } led_state_e;

  // Board clock and the default blink timing derived from it (50 ms on,
  // 50 ms off at 50 MHz).
  localparam int BOARD_CLK_HZ      = 50_000_000;
  localparam int DEFAULT_ON_TICKS  = BOARD_CLK_HZ / 20;
  localparam int DEFAULT_OFF_TICKS = BOARD_CLK_HZ / 20;

  // True when a tick count can be represented by a counter of the given
  // width once it is loaded as (ticks - 1).
  function automatic bit ticksInRange(input longint ticks, input int width);
    return (ticks >= 64'sd1) && (ticks <= (64'sd1 <<< width));
  endfunction

endpackage

// File: rtl/led_stretch_chan.sv
// Single LED channel: turns event strobes into blinks of fixed on-time and
// fixed off-gap, queuing events that arrive while a blink is in progress.
module led_stretch_chan
  import led_pkg::*;
#(
  parameter int   CNT_WIDTH  = 24,
  parameter int   ON_TICKS   = DEFAULT_ON_TICKS,
  parameter int   OFF_TICKS  = DEFAULT_OFF_TICKS,
  parameter int   PEND_WIDTH = 3,
  parameter logic INVERT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  input  logic pwm_gate,
  output logic led,
  output logic busy,
  output logic overflow
);

  // Reload values are (ticks - 1) truncated to the counter width, so a count
  // of 2^CNT_WIDTH loads as all-ones.
  localparam logic [CNT_WIDTH-1:0]  ON_LOAD  = CNT_WIDTH'(ON_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0]  OFF_LOAD = CNT_WIDTH'(OFF_TICKS - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

  led_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PEND_WIDTH-1:0] pending_q, pending_d;
  logic                  overflow_q, overflow_d;
  logic                  led_q, led_d;
  logic                  busy_q, busy_d;
  logic                  queueEvent;

  // State register: all channel state and the registered outputs update
  // together, and a synchronous reset abandons any blink in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= INVERT;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: phase sequencing, counter reload/decrement and the
  // saturating event queue.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    queueEvent = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev) begin
          state_d = ST_ON;
          cnt_d   = ON_LOAD;
        end
      end

      ST_ON: begin
        queueEvent = ev;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
          state_d = ST_GAP;
          cnt_d   = OFF_LOAD;
        end
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          queueEvent = ev;
          cnt_d      = cnt_q - CNT_WIDTH'(1);
        end else if (ev || (pending_q != '0)) begin
          // An event arriving on the last gap cycle is consumed straight
          // away; otherwise one queued event is taken off the queue.
          if (!ev) begin
            pending_d = pending_q - PEND_WIDTH'(1);
          end
          state_d = ST_ON;
          cnt_d   = ON_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pending_d = '0;
      end
    endcase

    if (queueEvent) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_WIDTH'(1);
      end
    end
  end

  // Output logic: computed from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    led_d  = ((state_d == ST_ON) && pwm_gate) ^ INVERT;
    busy_d = (state_d != ST_IDLE) || (pending_d != '0);
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Multi-channel LED pulse stretcher: one independent blink channel per event
// strobe. Define LED_PULSE_STRETCHER_PWM_EN to dim lit LEDs with a shared
// free-running PWM counter.
module led_pulse_stretcher
  import led_pkg::*;
#(
  parameter int   CHANNELS   = 8,
  parameter int   CNT_WIDTH  = 24,
  parameter int   ON_TICKS   = DEFAULT_ON_TICKS,
  parameter int   OFF_TICKS  = DEFAULT_OFF_TICKS,
  parameter int   PEND_WIDTH = 3,
  parameter logic INVERT     = 1'b0
`ifdef LED_PULSE_STRETCHER_PWM_EN
  ,
  parameter int   PWM_WIDTH  = 8,
  parameter int   PWM_DUTY   = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ev,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overflow
);

  // Reject timing that cannot be held in the phase counter.
  if (!ticksInRange(longint'(ON_TICKS), CNT_WIDTH)) begin : g_bad_on_ticks
    $error("led_pulse_stretcher: ON_TICKS must be in 1..2**CNT_WIDTH");
  end
  if (!ticksInRange(longint'(OFF_TICKS), CNT_WIDTH)) begin : g_bad_off_ticks
    $error("led_pulse_stretcher: OFF_TICKS must be in 1..2**CNT_WIDTH");
  end

  logic pwmGate;

`ifdef LED_PULSE_STRETCHER_PWM_EN
  if ((PWM_DUTY < 0) || (longint'(PWM_DUTY) > (64'sd1 <<< PWM_WIDTH))) begin : g_bad_pwm_duty
    $error("led_pulse_stretcher: PWM_DUTY must be in 0..2**PWM_WIDTH");
  end

  logic [PWM_WIDTH-1:0] pwmCnt_q, pwmCnt_d;

  // The gate is taken from the next count because the channel LEDs are
  // registered; the lit/unlit pattern then tracks the current count.
  always_comb begin
    pwmCnt_d = rst ? '0 : pwmCnt_q + PWM_WIDTH'(1);
    pwmGate  = int'(pwmCnt_d) < PWM_DUTY;
  end

  // Free-running dimming counter shared by every channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwmCnt_q <= '0;
    end else begin
      pwmCnt_q <= pwmCnt_d;
    end
  end
`else
  assign pwmGate = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_stretch_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .ON_TICKS  (ON_TICKS),
      .OFF_TICKS (OFF_TICKS),
      .PEND_WIDTH(PEND_WIDTH),
      .INVERT    (INVERT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .ev      (ev[i]),
      .pwm_gate(pwmGate),
      .led     (led[i]),
      .busy    (busy[i]),
      .overflow(overflow[i])
    );
  end

endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
- Multi-channel output-side companion to the input debouncer. It turns short internal event pulses into human-visible LED blinks.
- Each event produces exactly one blink: a guaranteed minimum on-time followed by a guaranteed minimum off-gap.
- Bursts of events are queued per channel and replayed as separate blinks.
- Sits between SoC status/activity strobes (bus activity, IRQ, UART traffic) and the board LED pins.

Parameters:
- CHANNELS, 8, number of independent LED channels.
- CNT_WIDTH, 24, width of the per-channel phase counter.
- ON_TICKS, 2500000, LED-on duration in clk cycles; legal range 1..2^CNT_WIDTH.
- OFF_TICKS, 2500000, forced off-gap after each blink in clk cycles; legal range 1..2^CNT_WIDTH.
- PEND_WIDTH, 3, width of the per-channel saturating pending-event counter.
- INVERT, 1'b0, output polarity; 1 gives active-low LED pins.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- ev, input, CHANNELS, event strobes; each cycle in which ev[i]=1 counts as one event.
- led, output, CHANNELS, LED drive, registered; "lit" means led[i] = ~INVERT.
- busy, output, CHANNELS, registered; 1 while channel i is in ON or GAP, or has pending>0.
- overflow, output, CHANNELS, sticky flag: an event was dropped because pending was saturated; cleared only by rst.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. When rst=1 at a clk edge, every channel goes to IDLE with cnt=0, pending=0, led=INVERT (unlit), busy=0, overflow=0. This applies mid-blink too: no partial blink is completed.
- Per-channel FSM, all registered:
  - IDLE: led unlit. If ev=1, load cnt=ON_TICKS-1 and go to ON. The LED is lit on the cycle after ev is sampled (latency 1).
  - ON: led lit. If cnt≠0, decrement cnt. If cnt=0, load cnt=OFF_TICKS-1 and go to GAP. The ON state lasts exactly ON_TICKS cycles.
  - GAP: led unlit. If cnt≠0, decrement cnt. If cnt=0:
    - effective pending (pending, or pending+1 if ev=1 this cycle) > 0: decrement it, load cnt=ON_TICKS-1, go to ON;
    - otherwise go to IDLE.
  - GAP therefore lasts exactly OFF_TICKS cycles. Back-to-back blinks have period ON_TICKS+OFF_TICKS.
- Pending counter:
  - ev=1 while in ON or GAP: pending+1, saturating at 2^PEND_WIDTH-1.
  - ev=1 with pending saturated: the event is dropped and overflow[i] is set.
  - ev=1 on the cycle GAP ends with pending>0: the increment and decrement cancel, so pending is unchanged.
  - ev=1 on the IDLE→ON cycle does not increment pending; that event is the one being displayed.
- busy[i] = (state≠IDLE) | (pending≠0), registered together with the state.
- Channels are fully independent. No arithmetic is shared across channels.
- ON_TICKS-1 and OFF_TICKS-1 are truncated to CNT_WIDTH bits. Parameter values outside the legal range are a configuration error; an elaboration-time check is required.

Optional Feature:
- Macro: LED_PULSE_STRETCHER_PWM_EN.
- Defined:
  - Adds parameters PWM_WIDTH (default 8) and PWM_DUTY (default 64).
  - Adds one free-running PWM_WIDTH-bit counter shared by all channels, reset to 0 by rst.
  - led[i] is lit only when state=ON and pwm_cnt < PWM_DUTY, giving dimmed LEDs.
  - PWM_DUTY = 2^PWM_WIDTH means fully lit.
  - FSM timing, busy and overflow are unaffected.
- Undefined: led[i] is lit for the whole ON state; no PWM logic exists.

Decomposition:
- Shared package (led_pkg):
  - state encoding typedef: IDLE=2'd0, ON=2'd1, GAP=2'd2; 2'd3 is illegal and recovers to IDLE;
  - constants for default ON/OFF tick counts at the board clock.
- One sub-module, led_stretch_chan: a single-channel FSM plus counters with ports clk, rst, ev, pwm_gate, led, busy, overflow.
- The top instantiates CHANNELS copies via generate and owns the optional PWM counter.

Test Plan (bench params: CHANNELS=2, CNT_WIDTH=4, ON_TICKS=4, OFF_TICKS=3, PEND_WIDTH=2, INVERT=0, PWM disabled):
- Single event: ev[0]=1 for one cycle at T0 → led[0]=1 during T1..T4, 0 during T5..T7; busy[0]=0 from T8; channel 1 stays idle.
- Burst: ev[0]=1 for 3 consecutive cycles → exactly 3 blinks, each 4 on / 3 off; pending peaks at 2; no overflow.
- Saturation: 5 consecutive ev[0] cycles → 4 blinks (1 displayed + 3 pending); overflow[0]=1 and stays 1 until rst.
- Simultaneous: ev[0]=1 on the final GAP cycle with pending=1 → next ON starts immediately, pending stays 1, two further blinks follow.
- Reset mid-blink: rst=1 during cycle T2 of ON → led=0, busy=0, overflow=0 on the next edge; a later event blinks normally with 1-cycle latency.
- INVERT=1 plus PWM build (PWM_WIDTH=2, PWM_DUTY=2): during ON, led toggles 0,0,1,1 (active-low) with pwm_cnt; led=1 while idle.
